// File: rtl/wb_bus_pkg.sv
// Shared constants and types for the two-master Wishbone peripheral bus arbiter.
// Holds the slave address map, the arbiter state enum and the default bus widths.
package wb_bus_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   // Slave map: ADR[7:4] selects the peripheral.
   localparam int         NUM_SLAVES = 3;
   localparam logic [3:0] SLV_PIO    = 4'h0;
   localparam logic [3:0] SLV_TIMER  = 4'h1;
   localparam logic [3:0] SLV_UART   = 4'h2;

   typedef enum logic [1:0] {
      IDLE,
      OWNED,
      ERR
   } arb_state_t;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and three slaves.
// The arbiter uses the slave modport; the surrounding system uses the master modport.
interface wb_bus_arbiter_if
   import wb_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              m0_cyc_i, m0_stb_i, m0_we_i;
   logic [ADDR_W-1:0] m0_adr_i;
   logic [DATA_W-1:0] m0_dat_i, m0_dat_o;
   logic              m0_ack_o, m0_err_o;

   logic              m1_cyc_i, m1_stb_i, m1_we_i;
   logic [ADDR_W-1:0] m1_adr_i;
   logic [DATA_W-1:0] m1_dat_i, m1_dat_o;
   logic              m1_ack_o, m1_err_o;

   logic [ADDR_W-1:0] s_adr_o;
   logic [DATA_W-1:0] s_dat_o;
   logic              s_we_o;
   logic              s0_stb_o, s1_stb_o, s2_stb_o;
   logic [DATA_W-1:0] s0_dat_i, s1_dat_i, s2_dat_i;
   logic              s0_ack_i, s1_ack_i, s2_ack_i;

   modport slave (
      input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
      input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
      input  s0_dat_i, s1_dat_i, s2_dat_i, s0_ack_i, s1_ack_i, s2_ack_i,
      output m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
      output s_adr_o, s_dat_o, s_we_o, s0_stb_o, s1_stb_o, s2_stb_o
   );

   modport master (
      output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
      output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
      output s0_dat_i, s1_dat_i, s2_dat_i, s0_ack_i, s1_ack_i, s2_ack_i,
      input  m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
      input  s_adr_o, s_dat_o, s_we_o, s0_stb_o, s1_stb_o, s2_stb_o
   );

endinterface

// File: rtl/wb_addr_decoder.sv
// Combinational peripheral decoder: ADR[7:4] to a one-hot slave select plus a mapped flag.
// Kept separate so a second bus segment can reuse the same map.
module wb_addr_decoder
   import wb_bus_pkg::*;
(
   input  logic [3:0]            i_adr_hi,
   output logic [NUM_SLAVES-1:0] o_sel,
   output logic                  o_mapped
);

   // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
   always_comb begin
      o_sel = '0;
      case (i_adr_hi)
         SLV_PIO:   o_sel[0] = 1'b1;
         SLV_TIMER: o_sel[1] = 1'b1;
         SLV_UART:  o_sel[2] = 1'b1;
         default:   o_sel = '0;
      endcase
   end

   assign o_mapped = |o_sel;

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter for two masters and three slaves, with address decode,
// read-data/ACK return muxing and error termination of unmapped or stalled accesses.
module wb_bus_arbiter
   import wb_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF
) (
   input logic             clk,
   input logic             rst,
   wb_bus_arbiter_if.slave bus
);

   arb_state_t r_state, w_state_nxt;
   logic       r_owner, w_owner_nxt;
   logic       r_prio, w_prio_nxt;
   logic [7:0] r_tmo_cnt, w_tmo_nxt, w_tmo_inc;

   logic                  w_cyc, w_stb, w_we, w_req0, w_req1;
   logic                  w_own, w_err, w_active, w_ack, w_mapped;
   logic [ADDR_W-1:0]     w_adr;
   logic [DATA_W-1:0]     w_wdat, w_rdata;
   logic [NUM_SLAVES-1:0] w_sel, w_sstb, w_sack;
   logic [DATA_W-1:0]     w_sdat [NUM_SLAVES];

   assign w_req0 = bus.m0_cyc_i && bus.m0_stb_i;
   assign w_req1 = bus.m1_cyc_i && bus.m1_stb_i;

   assign w_cyc  = r_owner ? bus.m1_cyc_i : bus.m0_cyc_i;
   assign w_stb  = r_owner ? bus.m1_stb_i : bus.m0_stb_i;
   assign w_we   = r_owner ? bus.m1_we_i  : bus.m0_we_i;
   assign w_adr  = r_owner ? bus.m1_adr_i : bus.m0_adr_i;
   assign w_wdat = r_owner ? bus.m1_dat_i : bus.m0_dat_i;

   wb_addr_decoder u_dec (
      .i_adr_hi (w_adr[7:4]),
      .o_sel    (w_sel),
      .o_mapped (w_mapped)
   );

   // Reset also gates the outputs so nothing reaches the bus while it is held.
   assign w_own    = (r_state == OWNED) && !rst;
   assign w_err    = (r_state == ERR) && !rst;
   assign w_active = w_own && w_cyc && w_stb;
   assign w_sstb   = w_active ? w_sel : '0;
   assign w_sack   = {bus.s2_ack_i, bus.s1_ack_i, bus.s0_ack_i};
   assign w_ack    = |(w_sstb & w_sack);

   assign w_sdat[0] = bus.s0_dat_i;
   assign w_sdat[1] = bus.s1_dat_i;
   assign w_sdat[2] = bus.s2_dat_i;

   always_comb begin
      w_rdata = '0;
      for (int n = 0; n < NUM_SLAVES; n++) begin
         if (w_sstb[n]) w_rdata = w_sdat[n];
      end
   end

   assign bus.s0_stb_o = w_sstb[0];
   assign bus.s1_stb_o = w_sstb[1];
   assign bus.s2_stb_o = w_sstb[2];
   assign bus.s_adr_o  = w_own ? w_adr  : '0;
   assign bus.s_dat_o  = w_own ? w_wdat : '0;
   assign bus.s_we_o   = w_own && w_we;

   assign bus.m0_dat_o = r_owner ? '0 : w_rdata;
   assign bus.m0_ack_o = !r_owner && w_ack;
   assign bus.m0_err_o = !r_owner && w_err;
   assign bus.m1_dat_o = r_owner ? w_rdata : '0;
   assign bus.m1_ack_o = r_owner && w_ack;
   assign bus.m1_err_o = r_owner && w_err;

   assign w_tmo_inc = r_tmo_cnt + 8'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_prio_nxt  = r_prio;
      w_tmo_nxt   = r_tmo_cnt;
      case (r_state)
         IDLE: begin
            w_tmo_nxt = '0;
            if (w_req0 || w_req1) begin
               w_state_nxt = OWNED;
               w_owner_nxt = (w_req0 && w_req1) ? r_prio : w_req1;
            end
         end
         OWNED: begin
            if (!w_cyc) begin
               w_state_nxt = IDLE;
               w_prio_nxt  = !r_owner;
               w_tmo_nxt   = '0;
            end else if (!w_stb || w_ack) begin
               w_tmo_nxt = '0;
            end else if (!w_mapped || w_tmo_inc == 8'(TIMEOUT_CYCLES)) begin
               w_state_nxt = ERR;
               w_tmo_nxt   = '0;
            end else begin
               w_tmo_nxt = w_tmo_inc;
            end
         end
         ERR: begin
            w_tmo_nxt = '0;
            if (!w_cyc) begin
               w_state_nxt = IDLE;
               w_prio_nxt  = !r_owner;
            end else begin
               w_state_nxt = OWNED;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_owner   <= 1'b0;
         r_prio    <= 1'b0;
         r_tmo_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_owner   <= w_owner_nxt;
         r_prio    <= w_prio_nxt;
         r_tmo_cnt <= w_tmo_nxt;
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: a directed vector table, hand-written
// multi-cycle sequences and a randomized run against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_wb_bus_arbiter;

   localparam int          TMO = 16;
   localparam int          NV  = 22;
   localparam logic [31:0] D0  = 32'hDEAD_BEEF;
   localparam logic [31:0] D1  = 32'h1111_1111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  m_cyc, m_stb, m_we;
   logic [7:0]  m_adr  [2];
   logic [31:0] m_wdat [2];
   logic [2:0]  s_ack;
   logic [31:0] s_rdat [3];
   logic [3:0]  regions [5];

   int n_pass  = 0;
   int n_total = 0;

   wb_bus_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

   assign bus.m0_cyc_i = m_cyc[0];
   assign bus.m0_stb_i = m_stb[0];
   assign bus.m0_we_i  = m_we[0];
   assign bus.m0_adr_i = m_adr[0];
   assign bus.m0_dat_i = m_wdat[0];
   assign bus.m1_cyc_i = m_cyc[1];
   assign bus.m1_stb_i = m_stb[1];
   assign bus.m1_we_i  = m_we[1];
   assign bus.m1_adr_i = m_adr[1];
   assign bus.m1_dat_i = m_wdat[1];
   assign bus.s0_ack_i = s_ack[0];
   assign bus.s1_ack_i = s_ack[1];
   assign bus.s2_ack_i = s_ack[2];
   assign bus.s0_dat_i = s_rdat[0];
   assign bus.s1_dat_i = s_rdat[1];
   assign bus.s2_dat_i = s_rdat[2];

   wb_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(8), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic        rst;
      logic [1:0]  cyc;
      logic [1:0]  stb;
      logic [7:0]  adr0;
      logic [7:0]  adr1;
      logic [2:0]  sack;
      logic [2:0]  e_sstb;
      logic [1:0]  e_ack;
      logic [1:0]  e_err;
      logic [7:0]  e_sadr;
      logic [31:0] e_sdat;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mkv(input logic r, input logic [1:0] c, s, input logic [7:0] a0, a1,
                                input logic [2:0] k, es, input logic [1:0] ea, ee,
                                input logic [7:0] ead, input logic [31:0] edt);
      vec_t v;
      v.rst = r;  v.cyc = c;  v.stb = s;  v.adr0 = a0;  v.adr1 = a1;  v.sack = k;
      v.e_sstb = es;  v.e_ack = ea;  v.e_err = ee;  v.e_sadr = ead;  v.e_sdat = edt;
      return v;
   endfunction

   function automatic logic [2:0] sstb();
      return {bus.s2_stb_o, bus.s1_stb_o, bus.s0_stb_o};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_masters();
      m_cyc = '0;
      m_stb = '0;
      s_ack = '0;
   endtask

   task automatic do_reset();
      idle_masters();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Behavioural model state: who holds the bus (-1 none), pending error, stall count, tie winner.
   int          holder, stall, tie, region;
   bit          in_err;
   logic [2:0]  e_sstb;
   logic [1:0]  e_ack, e_err;
   logic        e_swe;
   logic [7:0]  e_sadr;
   logic [31:0] e_sdat;
   logic [31:0] e_mdat [2];

   initial begin
      int  n_stb;
      bit  got_err;
      bit  r0, r1;

      regions = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF};
      idle_masters();
      m_we      = 2'b01;
      m_adr     = '{8'h00, 8'h00};
      m_wdat    = '{D0, D1};
      s_rdat    = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222};

      // rst cyc  stb  adr0   adr1   sack    e_sstb  ack    err    sadr   sdat
      vecs[0]  = mkv(1, 2'b00, 2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[1]  = mkv(0, 2'b00, 2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[2]  = mkv(0, 2'b01, 2'b01, 8'h04, 8'h00, 3'b001, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[3]  = mkv(0, 2'b01, 2'b01, 8'h04, 8'h00, 3'b001, 3'b001, 2'b01, 2'b00, 8'h04, D0);
      vecs[4]  = mkv(0, 2'b00, 2'b00, 8'h04, 8'h00, 3'b000, 3'b000, 2'b00, 2'b00, 8'h04, D0);
      vecs[5]  = mkv(1, 2'b00, 2'b00, 8'h04, 8'h00, 3'b000, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[6]  = mkv(0, 2'b11, 2'b11, 8'h04, 8'h14, 3'b011, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[7]  = mkv(0, 2'b11, 2'b11, 8'h04, 8'h14, 3'b011, 3'b001, 2'b01, 2'b00, 8'h04, D0);
      vecs[8]  = mkv(0, 2'b10, 2'b10, 8'h04, 8'h14, 3'b011, 3'b000, 2'b00, 2'b00, 8'h04, D0);
      vecs[9]  = mkv(0, 2'b11, 2'b11, 8'h04, 8'h14, 3'b011, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[10] = mkv(0, 2'b11, 2'b11, 8'h04, 8'h14, 3'b011, 3'b010, 2'b10, 2'b00, 8'h14, D1);
      vecs[11] = mkv(0, 2'b01, 2'b01, 8'h04, 8'h14, 3'b011, 3'b000, 2'b00, 2'b00, 8'h14, D1);
      vecs[12] = mkv(0, 2'b01, 2'b01, 8'h04, 8'h14, 3'b001, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[13] = mkv(0, 2'b01, 2'b01, 8'h04, 8'h14, 3'b001, 3'b001, 2'b01, 2'b00, 8'h04, D0);
      vecs[14] = mkv(0, 2'b00, 2'b00, 8'h04, 8'h14, 3'b000, 3'b000, 2'b00, 2'b00, 8'h04, D0);
      vecs[15] = mkv(0, 2'b00, 2'b00, 8'h30, 8'h00, 3'b000, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[16] = mkv(0, 2'b01, 2'b01, 8'h30, 8'h00, 3'b111, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);
      vecs[17] = mkv(0, 2'b01, 2'b01, 8'h30, 8'h00, 3'b111, 3'b000, 2'b00, 2'b00, 8'h30, D0);
      vecs[18] = mkv(0, 2'b01, 2'b00, 8'h30, 8'h00, 3'b111, 3'b000, 2'b00, 2'b01, 8'h00, 32'h0);
      vecs[19] = mkv(0, 2'b01, 2'b00, 8'h30, 8'h00, 3'b111, 3'b000, 2'b00, 2'b00, 8'h30, D0);
      vecs[20] = mkv(0, 2'b00, 2'b00, 8'h30, 8'h00, 3'b000, 3'b000, 2'b00, 2'b00, 8'h30, D0);
      vecs[21] = mkv(0, 2'b00, 2'b00, 8'h30, 8'h00, 3'b000, 3'b000, 2'b00, 2'b00, 8'h00, 32'h0);

      for (int i = 0; i < NV; i++) begin
         rst      = vecs[i].rst;
         m_cyc    = vecs[i].cyc;
         m_stb    = vecs[i].stb;
         m_adr[0] = vecs[i].adr0;
         m_adr[1] = vecs[i].adr1;
         s_ack    = vecs[i].sack;
         settle();
         check($sformatf("vec%0d slave strobes", i), sstb(), vecs[i].e_sstb);
         check($sformatf("vec%0d acks", i), {bus.m1_ack_o, bus.m0_ack_o}, vecs[i].e_ack);
         check($sformatf("vec%0d errs", i), {bus.m1_err_o, bus.m0_err_o}, vecs[i].e_err);
         check($sformatf("vec%0d s_adr", i), bus.s_adr_o, vecs[i].e_sadr);
         check($sformatf("vec%0d s_dat", i), bus.s_dat_o, vecs[i].e_sdat);
         tick();
      end

      // m1 reads the timer, which answers after three wait states.
      do_reset();
      m_we = 2'b00;  m_cyc = 2'b10;  m_stb = 2'b10;  m_adr[1] = 8'h18;  s_rdat[1] = 32'h0;
      settle();
      check("rd arbitration strobes", sstb(), 3'b000);
      tick();
      for (int w = 0; w < 3; w++) begin
         settle();
         check($sformatf("rd wait%0d strobe/ack", w), {sstb(), bus.m1_ack_o}, {3'b010, 1'b0});
         check($sformatf("rd wait%0d m0_dat", w), bus.m0_dat_o, 32'h0);
         tick();
      end
      s_ack = 3'b010;  s_rdat[1] = 32'h1234_5678;
      settle();
      check("rd m1_dat", bus.m1_dat_o, 32'h1234_5678);
      check("rd acks", {bus.m1_ack_o, bus.m0_ack_o}, 2'b10);
      check("rd m0_dat", bus.m0_dat_o, 32'h0);
      tick();
      idle_masters();
      tick();

      // m0 writes the UART, which never answers: timeout after TMO strobed cycles.
      do_reset();
      m_we = 2'b01;  m_cyc = 2'b01;  m_stb = 2'b01;  m_adr[0] = 8'h24;
      tick();
      n_stb   = 0;
      got_err = 1'b0;
      for (int c = 0; c < 40 && !got_err; c++) begin
         settle();
         if (bus.m0_err_o) got_err = 1'b1;
         else begin
            if (bus.s2_stb_o) n_stb++;
            tick();
         end
      end
      check("tmo err seen", 64'(got_err), 64'd1);
      check("tmo strobed cycles", 64'(n_stb), 64'(TMO));
      check("tmo err cycle strobes/ack", {sstb(), bus.m0_ack_o}, 4'b0000);
      m_stb = 2'b00;
      tick();
      settle();
      check("tmo err single pulse", {bus.m0_err_o, sstb()}, 4'b0000);
      idle_masters();
      tick();
      tick();

      // Reset during a stalled timer access restores m0 priority.
      do_reset();
      m_cyc = 2'b01;  m_stb = 2'b01;  m_adr[0] = 8'h04;  s_ack = 3'b001;
      tick();
      tick();
      idle_masters();
      tick();
      m_cyc = 2'b01;  m_stb = 2'b01;  m_adr[0] = 8'h10;
      tick();
      tick();
      settle();
      check("stall before rst", sstb(), 3'b010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_cyc = 2'b11;  m_stb = 2'b11;  m_adr[1] = 8'h04;  s_ack = 3'b011;
      settle();
      check("post-rst outputs", {sstb(), bus.m1_ack_o, bus.m0_ack_o, bus.m1_err_o, bus.m0_err_o}, 7'b0);
      check("post-rst s_adr", bus.s_adr_o, 8'h00);
      tick();
      settle();
      check("post-rst tie winner strobe", sstb(), 3'b010);
      check("post-rst tie winner adr", bus.s_adr_o, 8'h10);
      idle_masters();
      tick();
      tick();

      // Randomized traffic against the behavioural model.
      holder = -1;  in_err = 1'b0;  stall = 0;  tie = 0;
      for (int t = 0; t < 400; t++) begin
         rst = (t == 0) || ($urandom_range(0, 59) == 0);
         for (int m = 0; m < 2; m++) begin
            if ($urandom_range(0, 9) < 2) m_cyc[m] = !m_cyc[m];
            m_stb[m]  = ($urandom_range(0, 3) != 0);
            m_we[m]   = 1'($urandom_range(0, 1));
            m_adr[m]  = {regions[$urandom_range(0, 4)], 4'($urandom_range(0, 15))};
            m_wdat[m] = $urandom;
         end
         s_ack = 3'($urandom_range(0, 7));
         for (int s = 0; s < 3; s++) s_rdat[s] = $urandom;
         settle();

         e_sstb = '0;  e_ack = '0;  e_err = '0;  e_swe = 1'b0;
         e_sadr = '0;  e_sdat = '0;  e_mdat = '{32'h0, 32'h0};
         if (!rst && holder >= 0) begin
            if (in_err) e_err[holder] = 1'b1;
            else begin
               e_sadr = m_adr[holder];
               e_sdat = m_wdat[holder];
               e_swe  = m_we[holder];
               region = int'(m_adr[holder][7:4]);
               if (m_cyc[holder] && m_stb[holder] && region < 3) begin
                  e_sstb[region] = 1'b1;
                  e_ack[holder]  = s_ack[region];
                  e_mdat[holder] = s_rdat[region];
               end
            end
         end
         check($sformatf("rnd%0d ctl", t),
               {sstb(), bus.m1_ack_o, bus.m0_ack_o, bus.m1_err_o, bus.m0_err_o, bus.s_we_o},
               {e_sstb, e_ack, e_err, e_swe});
         check($sformatf("rnd%0d m_dat", t), {bus.m1_dat_o, bus.m0_dat_o}, {e_mdat[1], e_mdat[0]});
         check($sformatf("rnd%0d s_bus", t), {bus.s_adr_o, bus.s_dat_o}, {e_sadr, e_sdat});

         r0 = m_cyc[0] && m_stb[0];
         r1 = m_cyc[1] && m_stb[1];
         if (rst) begin
            holder = -1;  in_err = 1'b0;  stall = 0;  tie = 0;
         end else if (holder < 0) begin
            if (r0 && r1) holder = tie;
            else if (r0)  holder = 0;
            else if (r1)  holder = 1;
            stall = 0;
         end else if (!m_cyc[holder]) begin
            tie = 1 - holder;  holder = -1;  in_err = 1'b0;  stall = 0;
         end else if (in_err) begin
            in_err = 1'b0;  stall = 0;
         end else if (m_stb[holder]) begin
            region = int'(m_adr[holder][7:4]);
            if (region > 2) in_err = 1'b1;
            else if (s_ack[region]) stall = 0;
            else begin
               stall++;
               if (stall == TMO) begin
                  in_err = 1'b1;
                  stall  = 0;
               end
            end
         end else begin
            stall = 0;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Wishbone bus controller that shares the single peripheral bus between two masters (m0: CPU data port, m1: secondary master such as the interrupt controller or a future DMA) and the three slaves PIO, timer and UART. It grants bus tenure with round-robin arbitration, decodes `ADR[7:4]` into per-slave strobes and muxes read data and ACK back to the owner. It also terminates unmapped or unresponsive accesses with an error pulse. It sits between the masters and the slaves in `top_architecture` and replaces the free-standing decoder logic there.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16 — consecutive stalled cycles (STB high, no ACK) before error termination; legal range 2..255.
- `ADDR_W`, 8 — address width.
- `DATA_W`, 32 — data width.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `m0_cyc_i` / `m1_cyc_i`  in  1  — master cycle request; held for the whole tenure.
- `m0_stb_i` / `m1_stb_i`  in  1  — master strobe.
- `m0_we_i` / `m1_we_i`  in  1  — write enable.
- `m0_adr_i` / `m1_adr_i`  in  ADDR_W  — address.
- `m0_dat_i` / `m1_dat_i`  in  DATA_W  — write data.
- `m0_dat_o` / `m1_dat_o`  out  DATA_W  — read data; 0 when not owner.
- `m0_ack_o` / `m1_ack_o`  out  1  — transfer acknowledge.
- `m0_err_o` / `m1_err_o`  out  1  — error termination.
- `s_adr_o`  out  ADDR_W, `s_dat_o`  out  DATA_W, `s_we_o`  out  1  — shared slave-side address, write data and WE from the owner; 0 when idle.
- `s0_stb_o` / `s1_stb_o` / `s2_stb_o`  out  1  — strobes for PIO (`ADR[7:4]=0`), timer (1) and UART (2).
- `s0_dat_i` / `s1_dat_i` / `s2_dat_i`  in  DATA_W  — slave read data.
- `s0_ack_i` / `s1_ack_i` / `s2_ack_i`  in  1  — slave acknowledges.

## Operation
- States: IDLE, OWNED, ERR. Registers: `owner` (1 bit), `prio` (1 bit, the master that wins a tie), `tmo_cnt` (8 bits).
- IDLE: if any `mX_cyc_i & mX_stb_i` is high, grant it and go to OWNED. If both request, `prio` wins. Reset value of `prio` is m0.
- OWNED: the owner's ADR, DAT, WE and the gated STB are routed combinationally to the slaves. Exactly one `sN_stb_o` is high, given by `owner_cyc & owner_stb & mapped & ADR[7:4]==N`.
- The owner's `dat_o` is the selected slave's `dat_i`, and its `ack_o` is the selected slave's `ack_i`. The non-owner sees 0 on all outputs.
- ACKs from unselected slaves, or any ACK while no STB is high, are ignored.
- Unmapped address (`ADR[7:4] > 2`) with STB high: no slave strobe; go to ERR at the next edge.
- Timeout: `tmo_cnt` increments each OWNED cycle with STB high and no ACK, and clears on ACK or when STB is low. When it reaches `TIMEOUT_CYCLES`, go to ERR.
- ERR: the owner's `err_o` is high for exactly one cycle and all slave strobes are low. `tmo_cnt` clears and the state returns to OWNED. `err_o` and `ack_o` are never high together.
- Owner drops `cyc_i` in OWNED: go to IDLE at that edge and set `prio` to the other master. Tenure is kept for any number of back-to-back transfers while CYC is held.
- The non-owner's requests are ignored until IDLE. A master dropping CYC in ERR is handled the same way (ERR → IDLE).
- `rst`, including mid-transfer: at the next edge state=IDLE, `prio`=m0, `tmo_cnt`=0. All strobes, ACK, ERR, DAT and ADR outputs are 0 from that cycle on.

## Timing
- Arbitration latency is one cycle. A request first seen in IDLE at cycle N gives a slave strobe in cycle N+1.
- A zero-wait slave ACK in N+1 reaches the master in N+1. STB→strobe and ACK→ACK are combinational in OWNED.
- There is at least one IDLE cycle between two tenures.
- Unmapped access: STB high at cycle K in OWNED gives `err_o` at K+1.
- Timeout: STB high with no ACK for cycles K..K+TIMEOUT_CYCLES-1 gives `err_o` at K+TIMEOUT_CYCLES.
- All state, `owner`, `prio` and `tmo_cnt` are registered on `clk`. No latches, no combinational loop from `ack_i` to `stb_o`.

## Structure
- Package `wb_bus_pkg` holds:
  - slave map constants `SLV_PIO=4'h0`, `SLV_TIMER=4'h1`, `SLV_UART=4'h2`, `NUM_SLAVES=3`;
  - the state enum `arb_state_t {IDLE, OWNED, ERR}`;
  - the `ADDR_W`/`DATA_W` defaults.
- Sub-module `wb_addr_decoder`: combinational. Takes `adr[7:4]` and produces a one-hot slave select plus `mapped`. It is shared with any future second bus segment.

## Test plan
- After reset, m0 alone writes 0xDEADBEEF to 0x04. PIO ACKs with zero wait. Expect `s0_stb_o` one cycle after request, `m0_ack_o` in the same cycle, and `s_dat_o`=0xDEADBEEF.
- m0 and m1 request in the same cycle after reset. Expect m0 granted. When m0 drops CYC, expect one IDLE cycle, then m1 granted. On a later tie, expect m1 to win.
- m1 reads 0x18 while the timer returns 0x12345678 after 3 wait states. Expect `m1_dat_o`=0x12345678 with `m1_ack_o` and `m0_dat_o`=0 throughout.
- m0 accesses 0x30 (unmapped). Expect no slave strobe, `m0_err_o` for one cycle one cycle later, and no ACK.
- m0 accesses the UART, which never ACKs, with TIMEOUT_CYCLES=16. Expect `s2_stb_o` high for 16 cycles, then `m0_err_o` pulsed once with the strobe low.
- Assert `rst` in the middle of a stalled timer access. Expect all strobes and ACKs at 0 the next cycle, and m0 winning the next tie.
